regbank_wb_arbiter: RTL and testbench
=====================================

// Module: regbank_wb_arbiter
// PURPOSE
//  Shares the register bank's single write port between two writeback requesters: ALU and MEM (load return).
//  Each requester has a 1-entry holding slot with a valid/ready handshake.
//  Arbitration is oldest-first, so each destination register is written in request order.
//  A pending-write query port lets the hazard logic stall readers of in-flight registers.
//  Sits between the execute/memory stages and the register bank write port (writeFlag/regWrt/inData).
// PARAMETERS
//  DATA_W   32  write data width
//  ADDR_W    5  register index width (32 registers)
//  CNT_W    16  width of the saturating conflict counter
// PORTS
//  clk        in   1       clock; all state updates on its rising edge
//  rst_n      in   1       synchronous reset, active low
//  aluValid   in   1       ALU writeback request
//  aluReady   out  1       ALU slot can accept this cycle
//  aluReg     in   ADDR_W  ALU destination register
//  aluData    in   DATA_W  ALU result
//  memValid   in   1       MEM writeback request
//  memReady   out  1       MEM slot can accept this cycle
//  memReg     in   ADDR_W  MEM destination register
//  memData    in   DATA_W  load data
//  writeFlag  out  1       register bank write enable (registered)
//  regWrt     out  ADDR_W  register bank write index (registered)
//  inData     out  DATA_W  register bank write data (registered)
//  qReg       in   ADDR_W  hazard query register index
//  qPending   out  1       qReg has a write held or on the port this cycle (combinational)
//  conflicts  out  CNT_W   count of cycles with both slots held (saturating)
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge):
//   - writeFlag=0, regWrt=0, inData=0, conflicts=0.
//   - Both slots empty; age bit cleared.
//   - Any held requests are dropped; no write is issued in the following cycle.
//  Handshake:
//   - xReady = slot empty OR slot granted this cycle (combinational).
//   - Transfer occurs at a rising edge when xValid && xReady.
//   - Data is captured into the slot at that edge.
//  Register 0:
//   - A transfer with xReg==0 is accepted but discarded.
//   - The slot stays empty and no write is ever issued.
//  Age bit (old):
//   - Set to the slot that became occupied first.
//   - If both slots are captured at the same edge, MEM is older.
//  Grant (combinational each cycle):
//   - Exactly one slot held: grant it.
//   - Both slots held: grant the slot indicated by old.
//   - No slot held: no grant.
//  Write port timing:
//   - A grant at cycle N loads writeFlag=1, regWrt=slot.reg, inData=slot.data at edge N, and frees the slot.
//   - A cycle with no grant loads writeFlag=0; regWrt and inData hold their values.
//   - Minimum latency: request transferred at edge N, write port active after edge N+1.
//   - Throughput: one write per cycle.
//  Same-cycle refill: a slot granted at edge N may capture a new request at the same edge N.
//   - The new entry becomes younger than the other held slot.
//   - If the other slot is empty, the new entry is the only one, so old points to it.
//  qPending: 1 if any of the following holds; qReg==0 always returns 0.
//   - A held slot has reg==qReg.
//   - writeFlag && regWrt==qReg.
//  conflicts:
//   - Increments on every edge where both slots were held before the edge.
//   - Saturates at 2^CNT_W-1; no wrap.
// TESTING
//  1. Reset, then ALU req r5=0x11 at edge 1 -> writeFlag=1, regWrt=5, inData=0x11 after edge 2; aluReady stays 1.
//  2. ALU r3=0xA and MEM r4=0xB both transferred at edge 1 -> r4 written after edge 2, r3 after edge 3; conflicts=1.
//  3. MEM r7=1 held; ALU r7=2 arrives next cycle -> writes issue in order r7=1 then r7=2; qPending(7)=1 until the second write leaves the port.
//  4. ALU req r0=0xFF -> accepted (aluReady=1); writeFlag stays 0; qPending(0)=0.
//  5. Both slots held, drive rst_n=0 for one edge -> writeFlag=0 next cycle; both ready=1; conflicts=0; held entries never written.
//  6. Both requesters valid for 70000 cycles with CNT_W=16 -> conflicts saturates at 0xFFFF; at most one write per cycle; no request lost or reordered.

Source files
------------

// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter: shares the register bank write port between ALU and MEM writeback, oldest-first
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   aluValid/aluReady/aluReg/aluData  ALU writeback request handshake
//   memValid/memReady/memReg/memData  MEM (load return) writeback request handshake
//   writeFlag/regWrt/inData        registered register bank write port
//   qReg/qPending                  hazard query: is qReg held or being written
//   conflicts                      saturating count of cycles with both slots held
module regbank_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aluValid,
    output logic              aluReady,
    input  logic [ADDR_W-1:0] aluReg,
    input  logic [DATA_W-1:0] aluData,
    input  logic              memValid,
    output logic              memReady,
    input  logic [ADDR_W-1:0] memReg,
    input  logic [DATA_W-1:0] memData,
    output logic              writeFlag,
    output logic [ADDR_W-1:0] regWrt,
    output logic [DATA_W-1:0] inData,
    input  logic [ADDR_W-1:0] qReg,
    output logic              qPending,
    output logic [CNT_W-1:0]  conflicts
);
    logic              alu_h, mem_h, old_mem;
    logic [ADDR_W-1:0] alu_r, mem_r;
    logic [DATA_W-1:0] alu_d, mem_d;
    logic              alu_g, mem_g, alu_new, mem_new, alu_keep, mem_keep;

    always_comb begin
        alu_g    = alu_h && (!mem_h || !old_mem);
        mem_g    = mem_h && (!alu_h || old_mem);
        aluReady = !alu_h || alu_g;
        memReady = !mem_h || mem_g;
        // register 0 requests complete the handshake but never occupy a slot
        alu_new  = aluValid && aluReady && aluReg != '0;
        mem_new  = memValid && memReady && memReg != '0;
        alu_keep = alu_h && !alu_g;
        mem_keep = mem_h && !mem_g;
        qPending = qReg != '0 && ((alu_h && alu_r == qReg) || (mem_h && mem_r == qReg) ||
                                  (writeFlag && regWrt == qReg));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_h     <= 1'b0;
            mem_h     <= 1'b0;
            old_mem   <= 1'b0;
            writeFlag <= 1'b0;
            regWrt    <= '0;
            inData    <= '0;
            conflicts <= '0;
        end else begin
            alu_h <= alu_keep || alu_new;
            mem_h <= mem_keep || mem_new;
            if (alu_new) begin
                alu_r <= aluReg;
                alu_d <= aluData;
            end
            if (mem_new) begin
                mem_r <= memReg;
                mem_d <= memData;
            end
            // a surviving entry is older than anything captured now; MEM wins a same-edge tie
            old_mem   <= mem_keep || (!alu_keep && mem_new);
            writeFlag <= alu_g || mem_g;
            if (alu_g) begin
                regWrt <= alu_r;
                inData <= alu_d;
            end else if (mem_g) begin
                regWrt <= mem_r;
                inData <= mem_d;
            end
            if (alu_h && mem_h && conflicts != '1)
                conflicts <= conflicts + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// tb_regbank_wb_arbiter: randomized check of regbank_wb_arbiter against a FIFO-order reference model
module tb_regbank_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aluValid = 1'b0, memValid = 1'b0;
    logic        aluReady, memReady, writeFlag, qPending;
    logic [4:0]  aluReg = '0, memReg = '0, regWrt, qReg = '0;
    logic [31:0] aluData = '0, memData = '0, inData;
    logic [15:0] conflicts;

    regbank_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
        .writeFlag(writeFlag), .regWrt(regWrt), .inData(inData),
        .qReg(qReg), .qPending(qPending), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    // Oldest-first with one-entry slots means writes leave in exact acceptance order,
    // so the model is a single queue of accepted requests; the head is the grant.
    typedef struct {
        logic        src;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t        wq[$];
    logic        m_wf = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_dat = '0;
    logic [15:0] m_cnt = '0;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_ready(input logic src);
        for (int i = 1; i < wq.size(); i++)
            if (wq[i].src == src) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_pend(input logic [4:0] q);
        if (q == 0) return 1'b0;
        if (m_wf && m_reg == q) return 1'b1;
        foreach (wq[i]) if (wq[i].r == q) return 1'b1;
        return 1'b0;
    endfunction

    // one clock: drive at negedge, check comb outputs, advance model at posedge, check registers
    task automatic cycle(input logic rn, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] qq);
        logic a_rdy, m_rdy;
        ent_t e;
        rst_n = rn; aluValid = av; aluReg = ar; aluData = ad;
        memValid = mv; memReg = mr; memData = md; qReg = qq;
        #1;
        a_rdy = m_ready(1'b0);
        m_rdy = m_ready(1'b1);
        chk("aluReady", aluReady, a_rdy);
        chk("memReady", memReady, m_rdy);
        chk("qPending", qPending, m_pend(qq));
        @(posedge clk);
        if (!rn) begin
            wq.delete();
            m_wf = 0; m_reg = 0; m_dat = 0; m_cnt = 0;
        end else begin
            if (wq.size() == 2 && m_cnt != 16'hFFFF) m_cnt++;
            if (wq.size() > 0) begin
                e = wq.pop_front();
                m_wf = 1; m_reg = e.r; m_dat = e.d;
            end else m_wf = 0;
            if (mv && m_rdy && mr != 0) begin
                e.src = 1; e.r = mr; e.d = md; wq.push_back(e);
            end
            if (av && a_rdy && ar != 0) begin
                e.src = 0; e.r = ar; e.d = ad; wq.push_back(e);
            end
        end
        @(negedge clk);
        chk("writeFlag", writeFlag, m_wf);
        chk("regWrt", regWrt, m_reg);
        chk("inData", inData, m_dat);
        chk("conflicts", conflicts, m_cnt);
    endtask

    task automatic idle(input logic [4:0] qq);
        cycle(1, 0, 0, 0, 0, 0, 0, qq);
    endtask

    task automatic rst();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst();
        // single ALU write, two-cycle latency
        cycle(1, 1, 5, 32'h11, 0, 0, 0, 5);
        idle(5);
        chk("t1_wf", writeFlag, 1);
        chk("t1_reg", regWrt, 5);
        chk("t1_dat", inData, 32'h11);
        // simultaneous capture: MEM first
        rst();
        cycle(1, 1, 3, 32'hA, 1, 4, 32'hB, 3);
        idle(4);
        chk("t2_reg_a", regWrt, 4);
        chk("t2_dat_a", inData, 32'hB);
        chk("t2_cnt", conflicts, 1);
        idle(3);
        chk("t2_reg_b", regWrt, 3);
        chk("t2_dat_b", inData, 32'hA);
        // same destination, request order kept
        rst();
        cycle(1, 0, 0, 0, 1, 7, 32'h1, 7);
        cycle(1, 1, 7, 32'h2, 0, 0, 0, 7);
        chk("t3_dat_a", inData, 32'h1);
        idle(7);
        chk("t3_dat_b", inData, 32'h2);
        idle(7);
        chk("t3_idle", writeFlag, 0);
        idle(7);
        // register 0 is swallowed
        cycle(1, 1, 0, 32'hFF, 0, 0, 0, 0);
        idle(0);
        chk("t4_wf", writeFlag, 0);
        // reset drops held entries
        cycle(1, 1, 1, 32'h5, 1, 2, 32'h6, 1);
        rst();
        chk("t5_wf", writeFlag, 0);
        chk("t5_cnt", conflicts, 0);
        idle(2);
        chk("t5_wf2", writeFlag, 0);
        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
        // continuous contention until the counter saturates
        rst();
        for (int i = 0; i < 70000; i++)
            cycle(1, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom,
                  5'($urandom_range(0, 31)));
        chk("t6_sat", conflicts, 16'hFFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
